// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter from NUM_REQ cache requesters onto one tagged memory port.
// Optional MEM_ARB_DCACHE_PRIORITY_EN: requester 1 wins whenever eligible.
module mem_arbiter_rr #(
  parameter int NUM_REQ         = 2,
  parameter int TAG_W           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_W          = 64
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0][1:0]          req_command,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][63:0]         req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [TAG_W-1:0]                 req_tag,
  output logic [1:0]                       proc2mem_command,
  output logic [ADDR_W-1:0]                proc2mem_addr,
  output logic [63:0]                      proc2mem_data,
  input  logic [TAG_W-1:0]                 mem2proc_response,
  input  logic [63:0]                      mem2proc_data,
  input  logic [TAG_W-1:0]                 mem2proc_tag,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [63:0]                      resp_data,
  output logic [TAG_W-1:0]                 resp_tag
);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int DEPTH = 1 << TAG_W;
  localparam int PW    = $clog2(NUM_REQ);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0]      rr_q, rr_d;
  logic [CW-1:0]      cnt_q [NUM_REQ];
  logic [CW-1:0]      cnt_d [NUM_REQ];
  logic [DEPTH-1:0]   tv_q, tv_d;
  logic [PW-1:0]      town_q [DEPTH];
  logic [PW-1:0]      town_d [DEPTH];

  logic [NUM_REQ-1:0] elig, rr_elig;
  logic [PW-1:0]      win, idx, own;
  logic               found, drive, grant, ld_grant, rr_mv, hit;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] && req_command[i] != BUS_NONE &&
                !(req_command[i] == BUS_LOAD &&
                  cnt_q[i] == CW'(MAX_OUTSTANDING));
    end
    rr_elig = elig;
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    rr_elig[1] = 1'b0;
`endif
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    rr_mv = 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = PW'((int'(rr_q) + k) % NUM_REQ);
      if (!found && rr_elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
`ifdef MEM_ARB_DCACHE_PRIORITY_EN
    // dcache bypasses the rotation and leaves the pointer alone
    if (elig[1]) begin
      found = 1'b1;
      win   = PW'(1);
      rr_mv = 1'b0;
    end
`endif
  end

  always_comb begin
    drive    = found && !reset;
    grant    = drive && mem2proc_response != '0;
    ld_grant = grant && req_command[win] == BUS_LOAD;
    proc2mem_command = drive ? req_command[win] : BUS_NONE;
    proc2mem_addr    = drive ? req_addr[win] : '0;
    proc2mem_data    = drive ? req_data[win] : '0;
    req_ready = grant ? (NUM_REQ'(1) << win) : '0;
    req_tag   = grant ? mem2proc_response : '0;
  end

  // lookup uses the registered table, so a same-cycle allocation never matches
  always_comb begin
    own        = town_q[mem2proc_tag];
    hit        = !reset && mem2proc_tag != '0 && tv_q[mem2proc_tag];
    resp_valid = hit ? (NUM_REQ'(1) << own) : '0;
    resp_data  = hit ? mem2proc_data : '0;
    resp_tag   = hit ? mem2proc_tag : '0;
  end

  always_comb begin
    rr_d = rr_q;
    if (grant && rr_mv)
      rr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + PW'(1);
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ld_grant && win == PW'(i) && !(hit && own == PW'(i)))
        cnt_d[i] = cnt_q[i] + CW'(1);
      else if (hit && own == PW'(i) && !(ld_grant && win == PW'(i)))
        cnt_d[i] = cnt_q[i] - CW'(1);
    end
    tv_d   = tv_q;
    town_d = town_q;
    if (hit)
      tv_d[mem2proc_tag] = 1'b0;
    if (ld_grant) begin
      tv_d[mem2proc_response]   = 1'b1;
      town_d[mem2proc_response] = win;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_q <= '0;
      tv_q <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        cnt_q[i] <= '0;
    end else begin
      rr_q  <= rr_d;
      tv_q  <= tv_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    town_q <= town_d;
  end

endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
Parametrised memory arbiter connecting NUM_REQ cache-side requesters (icache, dcache, prefetcher, ...) to the single tagged memory port. Each cycle it selects one requester round-robin and drives that requester's command and address to memory. It records each load's granted tag in a tag-indexed ownership table, routes returned data to the owning requester only, and caps loads in flight per requester.

Parameters:
NUM_REQ, 2, number of requester channels (>=2); index 0 = icache, 1 = dcache by convention
TAG_W, 4, memory tag width; table depth 2**TAG_W; tag 0 means "none"
MAX_OUTSTANDING, 4, max loads in flight per requester (1..2**TAG_W-1)
ADDR_W, 64, address width to memory

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a command pending
req_command  in  NUM_REQ x 2  BUS_LOAD / BUS_STORE per requester
req_addr  in  NUM_REQ x ADDR_W  address per requester
req_data  in  NUM_REQ x 64  store data per requester
req_ready  out  NUM_REQ  one-hot; requester i granted this cycle
req_tag  out  TAG_W  tag granted this cycle (valid with req_ready)
proc2mem_command  out  2  command to memory
proc2mem_addr  out  ADDR_W  address to memory
proc2mem_data  out  64  store data to memory
mem2proc_response  in  TAG_W  nonzero = command accepted with this tag
mem2proc_data  in  64  returned load data
mem2proc_tag  in  TAG_W  nonzero = data for this tag
resp_valid  out  NUM_REQ  one-hot; data for requester i
resp_data  out  64  returned data (broadcast)
resp_tag  out  TAG_W  returned tag (broadcast)

Behaviour:
- Eligibility: eligible[i] = req_valid[i] && req_command[i] != BUS_NONE && !(req_command[i]==BUS_LOAD && out_cnt[i]==MAX_OUTSTANDING).
- Winner: first eligible index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. Combinational.
- proc2mem_command/addr/data = winner's fields. When there is no winner, or during reset: BUS_NONE, 0, 0.
- Grant: mem2proc_response != 0 while a winner is driven. req_ready[winner]=1 and req_tag=mem2proc_response in the same cycle. Otherwise req_ready=0 and req_tag=0.
- rr_ptr (reset 0) <= (winner+1) mod NUM_REQ on grant only. No grant leaves it unchanged, so the same winner retries next cycle.
- Load grant: table[tag] <= {valid=1, owner=winner}; out_cnt[winner]++.
- Store grant: no table entry, no counter change; stores produce no data response.
- Data return: mem2proc_tag != 0 and table[tag].valid (registered table) gives resp_valid[owner]=1, resp_data=mem2proc_data, resp_tag=mem2proc_tag, all the same cycle. Then table[tag].valid <= 0 and out_cnt[owner]--.
- Orphan return: tag not valid in the table gives all resp outputs 0; no state change.
- No return: resp_valid=0, resp_data=0, resp_tag=0.
- Simultaneous load grant and return, same requester: out_cnt unchanged.
- Simultaneous grant and return, same tag: allocation wins and the entry stays valid with the new owner; the return is still routed to the old owner.
- A grant and a return in the same cycle with a freshly allocated tag cannot match, because lookup uses the registered table.
- Counters saturate-guarded: never exceed MAX_OUTSTANDING and never drop below 0, enforced by the eligibility mask.
- Reset: table valid bits, out_cnt and rr_ptr cleared; all outputs 0/BUS_NONE. Data returning after a mid-operation reset is treated as orphan and dropped.

Optional Feature:
MEM_ARB_DCACHE_PRIORITY_EN
- Defined: requester 1 (dcache), when eligible, always wins regardless of rr_ptr. A grant to requester 1 does not move rr_ptr; the other requesters keep round-robin among themselves.
- Undefined: pure round-robin over all requesters as above.

Test Plan:
- Reset, then req_valid=2'b11 both BUS_LOAD, mem2proc_response=3 -> req_ready=01, req_tag=3, rr_ptr=1. Next cycle response=5 -> req_ready=10, req_tag=5.
- mem2proc_response=0 for 3 cycles with req0 valid -> req_ready=0, proc2mem_command stays BUS_LOAD at req0 addr; grant on cycle 4 goes to req0.
- Load grant to req1 tag 7, then mem2proc_tag=7 data=64'hDEAD_BEEF -> resp_valid=10, resp_data=DEAD_BEEF, resp_tag=7. A second return on tag 7 is an orphan -> resp_valid=0.
- req0 issues 4 loads (tags 1-4) with no returns -> req0 masked, req1 store granted, no table entry. A return on tag 2 re-enables req0 the next cycle.
- Same-cycle load grant to req0 plus return of req0's tag 1 -> out_cnt[0] unchanged, resp_valid=01.
- Reset asserted with 3 loads outstanding, then mem2proc_tag=2 -> resp_valid=0, all out_cnt=0. With MEM_ARB_DCACHE_PRIORITY_EN and both valid -> req1 granted on every cycle.
